// File: rtl/tlb_refill_if.sv
// tlb_refill_if: bundles the miss, page-table read and TLB write
// signals of the refill unit; slave = refill unit, master = its peers.
interface tlb_refill_if #(
  parameter int IDX_W = 2
);
  logic             miss_valid;
  logic [19:0]      miss_vpn;
  logic             miss_ready;
  logic [26:0]      ptbase;
  logic             mem_rd_req;
  logic [26:0]      mem_addr;
  logic             mem_rd_ack;
  logic [31:0]      mem_rdata;
  logic             tlb_we;
  logic [IDX_W-1:0] tlb_index;
  logic [34:0]      tlb_wdata;
  logic             done;
  logic             fault;
  logic             timeout;

  modport slave (
    input  miss_valid, miss_vpn, ptbase,
    input  mem_rd_ack, mem_rdata,
    output miss_ready, mem_rd_req, mem_addr,
    output tlb_we, tlb_index, tlb_wdata,
    output done, fault, timeout
  );

  modport master (
    output miss_valid, miss_vpn, ptbase,
    output mem_rd_ack, mem_rdata,
    input  miss_ready, mem_rd_req, mem_addr,
    input  tlb_we, tlb_index, tlb_wdata,
    input  done, fault, timeout
  );
endinterface

// File: rtl/tlb_refill.sv
// tlb_refill: TLB miss handler; PTE fetch and round-robin slot write.
// Optional read timeout via `define TLB_REFILL_TIMEOUT_EN.
module tlb_refill #(
  parameter int ENTRIES        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic         clk,
  input logic         reset_n,
  tlb_refill_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t state, state_n;

  logic [19:0]      vpn;
  logic [IDX_W-1:0] ptr;
  logic             fault_n;
  logic             timeout_n;

  logic             miss_ready_q;
  logic             mem_rd_req_q;
  logic [26:0]      mem_addr_q;
  logic             tlb_we_q;
  logic [IDX_W-1:0] tlb_index_q;
  logic [34:0]      tlb_wdata_q;
  logic             done_q;
  logic             fault_q;
  logic             timeout_q;

  logic             unused_bits;
  assign unused_bits = ^{bus.mem_rdata[31:27],
                         bus.mem_rdata[11:1]};

`ifdef TLB_REFILL_TIMEOUT_EN
  localparam int CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
    $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt;
  logic             expire;

  // cnt + 1 = READ cycles without ack, this one included
  assign expire =
    (cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state != READ) begin
      cnt <= '0;
    end else if (!bus.mem_rd_ack) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic expire;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    fault_n   = 1'b0;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.miss_valid) state_n = READ;
      end
      READ: begin
        if (bus.mem_rd_ack) begin
          if (bus.mem_rdata[0]) begin
            state_n = WRITE;
          end else begin
            state_n = RESP;
            fault_n = 1'b1;
          end
        end else if (expire) begin
          state_n   = RESP;
          fault_n   = 1'b1;
          timeout_n = 1'b1;
        end
      end
      WRITE: state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs are registered copies of the next-state decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      vpn          <= '0;
      ptr          <= '0;
      miss_ready_q <= 1'b1;
      mem_rd_req_q <= 1'b0;
      mem_addr_q   <= '0;
      tlb_we_q     <= 1'b0;
      tlb_index_q  <= '0;
      tlb_wdata_q  <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state        <= state_n;
      miss_ready_q <= (state_n == IDLE);
      mem_rd_req_q <= (state_n == READ);
      tlb_we_q     <= (state_n == WRITE);
      done_q       <= (state_n == RESP);
      fault_q      <= fault_n;
      timeout_q    <= timeout_n;
      if (state == IDLE && bus.miss_valid) begin
        vpn        <= bus.miss_vpn;
        mem_addr_q <= bus.ptbase +
                      {5'b0, bus.miss_vpn, 2'b00};
      end
      if (state == READ && state_n == WRITE) begin
        tlb_wdata_q <= {vpn, bus.mem_rdata[26:12]};
        tlb_index_q <= ptr;
      end
      if (state == WRITE) begin
        ptr <= (ptr == IDX_W'(ENTRIES - 1)) ?
               '0 : ptr + IDX_W'(1);
      end
    end
  end

  assign bus.miss_ready = miss_ready_q;
  assign bus.mem_rd_req = mem_rd_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.tlb_we     = tlb_we_q;
  assign bus.tlb_index  = tlb_index_q;
  assign bus.tlb_wdata  = tlb_wdata_q;
  assign bus.done       = done_q;
  assign bus.fault      = fault_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_tlb_refill.sv
// tb_tlb_refill: directed vectors for the TLB refill unit.
// Timeout cases run when TLB_REFILL_TIMEOUT_EN is defined.
module tb_tlb_refill;

  localparam int IDX_W = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  tlb_refill_if #(.IDX_W(IDX_W)) bus ();

  tlb_refill #(
    .ENTRIES(4),
    .IDX_W(IDX_W),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // leaves the bench in cycle 1 after the accept edge
  task automatic do_req(input logic [26:0] pb,
                        input logic [19:0] v);
    bus.ptbase     = pb;
    bus.miss_vpn   = v;
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid = 1'b0;
  endtask

  task automatic fill(input logic [26:0] pb,
                      input logic [19:0] v,
                      input logic [31:0] rd,
                      input int          wait_n,
                      input logic [26:0] exp_addr,
                      input logic [34:0] exp_wdata,
                      input logic [1:0]  exp_idx);
    do_req(pb, v);
    chk("req_c1", 64'(bus.mem_rd_req), 64'h1);
    chk("addr", 64'(bus.mem_addr), 64'(exp_addr));
    chk("ready_c1", 64'(bus.miss_ready), 64'h0);
    repeat (wait_n) step();
    if (wait_n > 0) begin
      chk("req_wait", 64'(bus.mem_rd_req), 64'h1);
      chk("done_wait", 64'(bus.done), 64'h0);
    end
    bus.mem_rdata  = rd;
    bus.mem_rd_ack = 1'b1;
    step();
    bus.mem_rd_ack = 1'b0;
    chk("req_drop", 64'(bus.mem_rd_req), 64'h0);
    if (rd[0]) begin
      chk("we", 64'(bus.tlb_we), 64'h1);
      chk("idx", 64'(bus.tlb_index), 64'(exp_idx));
      chk("wdata", 64'(bus.tlb_wdata), 64'(exp_wdata));
      chk("done_early", 64'(bus.done), 64'h0);
      step();
      chk("done", 64'(bus.done), 64'h1);
      chk("fault", 64'(bus.fault), 64'h0);
      chk("timeout", 64'(bus.timeout), 64'h0);
      chk("we_once", 64'(bus.tlb_we), 64'h0);
    end else begin
      chk("done_f", 64'(bus.done), 64'h1);
      chk("fault_f", 64'(bus.fault), 64'h1);
      chk("timeout_f", 64'(bus.timeout), 64'h0);
      chk("we_f", 64'(bus.tlb_we), 64'h0);
    end
    step();
    chk("ready_back", 64'(bus.miss_ready), 64'h1);
    chk("done_pulse", 64'(bus.done), 64'h0);
    chk("fault_low", 64'(bus.fault), 64'h0);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.miss_valid = 1'b0;
    bus.miss_vpn   = '0;
    bus.ptbase     = '0;
    bus.mem_rd_ack = 1'b0;
    bus.mem_rdata  = '0;
    repeat (2) step();
    chk("rst_ready", 64'(bus.miss_ready), 64'h1);
    chk("rst_req", 64'(bus.mem_rd_req), 64'h0);
    chk("rst_we", 64'(bus.tlb_we), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_fault", 64'(bus.fault), 64'h0);
    chk("rst_timeout", 64'(bus.timeout), 64'h0);
    chk("rst_addr", 64'(bus.mem_addr), 64'h0);
    chk("rst_wdata", 64'(bus.tlb_wdata), 64'h0);
    chk("rst_idx", 64'(bus.tlb_index), 64'h0);
    reset_n = 1'b1;
    step();

    // stray ack while idle
    bus.mem_rdata  = 32'h0ABCD001;
    bus.mem_rd_ack = 1'b1;
    step();
    step();
    bus.mem_rd_ack = 1'b0;
    chk("idle_ack_ready", 64'(bus.miss_ready), 64'h1);
    chk("idle_ack_we", 64'(bus.tlb_we), 64'h0);
    chk("idle_ack_req", 64'(bus.mem_rd_req), 64'h0);

    fill(27'h0001000, 20'h00003, 32'h0ABCD001, 0,
         27'h000100C, {20'h00003, 15'h2BCD}, 2'd0);
    fill(27'h0001000, 20'h00005, 32'h0ABCD000, 0,
         27'h0001014, 35'h0, 2'd0);
    fill(27'h0002000, 20'h00010, 32'h00012001, 2,
         27'h0002040, {20'h00010, 15'h0012}, 2'd1);

    // reset while the read is outstanding
    do_req(27'h0001000, 20'h00007);
    chk("mid_req", 64'(bus.mem_rd_req), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(bus.mem_rd_req), 64'h0);
    chk("mid_rst_ready", 64'(bus.miss_ready), 64'h1);
    chk("mid_rst_we", 64'(bus.tlb_we), 64'h0);
    chk("mid_rst_addr", 64'(bus.mem_addr), 64'h0);
    step();
    reset_n        = 1'b1;
    bus.mem_rdata  = 32'h0ABCD001;
    bus.mem_rd_ack = 1'b1;
    step();
    bus.mem_rd_ack = 1'b0;
    chk("late_ack_ready", 64'(bus.miss_ready), 64'h1);
    chk("late_ack_we", 64'(bus.tlb_we), 64'h0);
    step();
    chk("late_ack_done", 64'(bus.done), 64'h0);

    // five fills after reset: index 0,1,2,3,0
    fill(27'h7FFFFFC, 20'h00002, 32'h00001001, 0,
         27'h0000004, {20'h00002, 15'h0001}, 2'd0);
    fill(27'h0000000, 20'h00011, 32'h07FFF001, 1,
         27'h0000044, {20'h00011, 15'h7FFF}, 2'd1);
    fill(27'h0000000, 20'hFFFFF, 32'hFFFFF001, 0,
         27'h03FFFFC, {20'hFFFFF, 15'h7FFF}, 2'd2);
    fill(27'h0000100, 20'h00020, 32'h00555001, 3,
         27'h0000180, {20'h00020, 15'h0555}, 2'd3);
    fill(27'h0000000, 20'h00010, 32'h00002001, 0,
         27'h0000040, {20'h00010, 15'h0002}, 2'd0);

`ifdef TLB_REFILL_TIMEOUT_EN
    // no ack: expiry after four read cycles
    do_req(27'h0000000, 20'h00001);
    repeat (3) step();
    chk("to_req_c4", 64'(bus.mem_rd_req), 64'h1);
    chk("to_done_c4", 64'(bus.done), 64'h0);
    step();
    chk("to_done", 64'(bus.done), 64'h1);
    chk("to_fault", 64'(bus.fault), 64'h1);
    chk("to_timeout", 64'(bus.timeout), 64'h1);
    chk("to_req_low", 64'(bus.mem_rd_req), 64'h0);
    chk("to_we", 64'(bus.tlb_we), 64'h0);
    step();
    chk("to_ready", 64'(bus.miss_ready), 64'h1);
    chk("to_timeout_low", 64'(bus.timeout), 64'h0);
    // ack exactly on the expiry cycle wins
    fill(27'h0000000, 20'h00009, 32'h00033001, 3,
         27'h0000024, {20'h00009, 15'h0033}, 2'd1);
`else
    // read waits well past TIMEOUT_CYCLES
    fill(27'h0000000, 20'h00009, 32'h00033001, 20,
         27'h0000024, {20'h00009, 15'h0033}, 2'd1);
    chk("no_to_timeout", 64'(bus.timeout), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
